// File: rtl/tt_um_crc3_if.sv
// rtl/tt_um_crc3_if.sv - Tiny Tapeout pin bundle for the serial CRC-3 tile
//
// Groups the tile's user pins: ena, ui_in, uio_in (tile inputs) and
// uo_out, uio_out, uio_oe (tile outputs). The master modport drives the tile
// inputs; the slave modport is the tile itself.
interface tt_um_crc3_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_crc3.sv
// rtl/tt_um_crc3.sv - serial CRC-3 (x^3+x+1) generator tile with gated registers
//
// Ports:
//   clk          tile clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus.ena      tile enable, bits accepted only when 1
//   bus.ui_in    [0] shift_en, [1] serial data, [2] synchronous clear
//   bus.uo_out   {msg[4:0], crc[2:0]}, msg[4] is the first bit received
//   bus.uio_out  [0] done, rest 0
//   bus.uio_oe   constant 8'h01
//
// A frame is 8 bits, MSB first: 5 message bits then 3 pad bits. The message
// register captures the first 5 bits; the CRC register runs over all 8, so
// after the frame it holds the remainder of {msg,000} mod 1011.
module tt_um_crc3 (
    input  logic          clk,
    input  logic          rst_n,
    tt_um_crc3_if.slave   bus
);
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] msg_q, msg_d;
    logic [2:0] crc_q, crc_d;

    logic done;
    logic clear;
    logic shift_en;
    logic data;
    logic accept;
    logic msg_phase;

    assign shift_en  = bus.ui_in[0];
    assign data      = bus.ui_in[1];
    assign clear     = bus.ui_in[2];
    assign done      = (cnt_q == 4'd8);
    assign accept    = bus.ena & shift_en & ~done & ~clear;
    assign msg_phase = (cnt_q < 4'd5);

    always_comb begin
        cnt_d = cnt_q;
        msg_d = msg_q;
        crc_d = crc_q;
        if (clear) begin
            cnt_d = 4'd0;
            msg_d = 5'd0;
            crc_d = 3'd0;
        end else if (accept) begin
            // Feedback taps of 1011 below the x^3 term are 011.
            crc_d = {crc_q[1:0], data} ^ (crc_q[2] ? 3'b011 : 3'b000);
            if (msg_phase) begin
                msg_d = {msg_q[3:0], data};
            end
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Clock gate enables. Each register group only sees an edge on cycles
    // where it actually changes.
    logic en_a, en_b, en_c;
    assign en_a = accept | clear;
    assign en_b = (accept & msg_phase) | clear;
    assign en_c = accept | clear;

    // Latch-based ICGs: the enable is captured while clk is low and frozen
    // while clk is high, so the AND cannot glitch during the high phase.
    logic en_a_l, en_b_l, en_c_l;

    always_latch begin
        if (!clk) begin
            en_a_l <= en_a;
        end
    end

    always_latch begin
        if (!clk) begin
            en_b_l <= en_b;
        end
    end

    always_latch begin
        if (!clk) begin
            en_c_l <= en_c;
        end
    end

    logic gclk_a, gclk_b, gclk_c;
    assign gclk_a = clk & en_a_l;
    assign gclk_b = clk & en_b_l;
    assign gclk_c = clk & en_c_l;

    // Reset reaches every register directly, whatever the gate state.
    always_ff @(posedge gclk_a or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 3'd0;
        end else begin
            crc_q <= crc_d;
        end
    end

    always_ff @(posedge gclk_b or negedge rst_n) begin
        if (!rst_n) begin
            msg_q <= 5'd0;
        end else begin
            msg_q <= msg_d;
        end
    end

    always_ff @(posedge gclk_c or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.uo_out  = {msg_q, crc_q};
    assign bus.uio_out = {7'd0, done};
    assign bus.uio_oe  = 8'h01;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.uio_in, bus.ui_in[7:3]};
endmodule

// File: tb/tb_tt_um_crc3.sv
// tb/tb_tt_um_crc3.sv - directed self-checking bench for tt_um_crc3
module tb_tt_um_crc3;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tt_um_crc3_if bus ();

    tt_um_crc3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One rising edge with the given pin values; outputs are sampled 1 ns later.
    task automatic edge_in(input logic shift, input logic d, input logic clr);
        @(negedge clk);
        bus.ui_in = {5'd0, clr, d, shift};
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            edge_in(1'b1, bits[7 - i], 1'b0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_uo_out", bus.uo_out, 8'h00);
        chk("reset_uio_out", bus.uio_out, 8'h00);
        chk("uio_oe", bus.uio_oe, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 10101 000 -> msg 10101, crc 101.
        send_bits(8'b1010_1000, 8);
        chk("t1_uo_out", bus.uo_out, 8'hAD);
        chk("t1_done", bus.uio_out, 8'h01);

        // Saturation: extra bits change nothing.
        send_bits(8'b1110_0000, 3);
        chk("t2_uo_out", bus.uo_out, 8'hAD);
        chk("t2_done", bus.uio_out, 8'h01);

        edge_in(1'b0, 1'b0, 1'b1);
        chk("clear_uo_out", bus.uo_out, 8'h00);
        chk("clear_done", bus.uio_out, 8'h00);

        // 11111000 mod 1011 = 110.
        send_bits(8'b1111_1000, 8);
        chk("t3_uo_out", bus.uo_out, 8'hFE);
        chk("t3_done", bus.uio_out, 8'h01);
        edge_in(1'b0, 1'b0, 1'b1);

        // Pause mid-frame.
        send_bits(8'b1010_0000, 3);
        chk("t4_partial", bus.uo_out, 8'h2D);
        chk("t4_partial_done", bus.uio_out, 8'h00);
        for (int i = 0; i < 4; i++) begin
            edge_in(1'b0, 1'b1, 1'b0);
        end
        chk("t4_paused", bus.uo_out, 8'h2D);
        send_bits(8'b0100_0000, 5);
        chk("t4_uo_out", bus.uo_out, 8'hAD);
        chk("t4_done", bus.uio_out, 8'h01);

        // Clear wins over a simultaneous shift.
        edge_in(1'b1, 1'b1, 1'b1);
        chk("clear_prio_uo_out", bus.uo_out, 8'h00);
        chk("clear_prio_done", bus.uio_out, 8'h00);

        // Frame 00001 000 -> crc 011; done only on the eighth bit.
        send_bits(8'b0000_1000, 7);
        chk("t5_seven_bits", bus.uo_out, 8'h0C);
        chk("t5_not_done", bus.uio_out, 8'h00);
        send_bits(8'b0000_0000, 1);
        chk("t5_uo_out", bus.uo_out, 8'h0B);
        chk("t5_done", bus.uio_out, 8'h01);
        edge_in(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame while clk is high.
        send_bits(8'b1100_0000, 2);
        chk("t6_partial", bus.uo_out, 8'h1B);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", bus.uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // ena low: bits ignored.
        bus.ena = 1'b0;
        send_bits(8'b1110_0000, 3);
        chk("t6_ena_low", bus.uo_out, 8'h00);
        chk("t6_ena_low_done", bus.uio_out, 8'h00);
        bus.ena = 1'b1;
        send_bits(8'b1010_0000, 3);
        chk("t6_resume", bus.uo_out, 8'h2D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
